// File: rtl/access_pkg.sv
// ---------------------------------------------------------------------------
// access_pkg
// Shared definitions for the access-code transmitter:
//   - state_t     : FSM state encoding (also driven out on state_out)
//   - KEY_*       : keypad codes (digits 0x0-0xB, clear 0xC, enter 0xE)
//   - DEF_*       : default values for the block parameters
//   - is_digit()  : classifies a key code as a digit
// ---------------------------------------------------------------------------
package access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENTRY     = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_GRANTED   = 3'd4,
    ST_LOCKED    = 3'd5
  } state_t;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'hB;
  localparam logic [3:0] KEY_CLEAR     = 4'hC;
  localparam logic [3:0] KEY_ENTER     = 4'hE;

  localparam int DEF_RESP_TIMEOUT = 4;
  localparam int DEF_MAX_FAILS    = 3;
  localparam int DEF_LOCK_CYCLES  = 64;

  // Key codes above the last digit are either commands or unused.
  function automatic logic is_digit(input logic [3:0] key);
    return (key <= KEY_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/access_timer.sv
// ---------------------------------------------------------------------------
// access_timer
// Loadable down-counter shared by the response timeout and the lockout.
// The owner loads (duration - 1) on the edge that enters the timed state and
// enables counting while in that state; o_zero then marks the final cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (count cleared)
//   i_load     in   load i_load_val on the next edge (wins over i_en)
//   i_en       in   decrement on the next edge while the count is non-zero
//   i_load_val in   WIDTH  value to load
//   o_zero     out  count is zero
// ---------------------------------------------------------------------------
module access_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Load has priority so a new timed interval can start on the same edge the
  // previous one ends; the counter parks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/access_code_tx.sv
// ---------------------------------------------------------------------------
// access_code_tx
// Keypad front end for a door controller. Digits select a one-digit code,
// clear abandons entry, enter sends the code with a one-cycle validate_code
// strobe, then the block waits for the door controller to open the door.
// Too slow an answer counts as a rejection.
//
// Optional feature (macro ACCESS_LOCKOUT_EN): MAX_FAILS consecutive
// rejections lock the keypad out for LOCK_CYCLES cycles. Without the macro
// there is no fail counter, no LOCKED state and locked is tied low.
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   synchronous active-high reset
//   key_valid        in   one-cycle strobe marking a keypad press
//   key_val          in   4  key code (0x0-0xB digit, 0xC clear, 0xE enter)
//   open_access_door in   door-open indication from the door controller
//   validate_code    out  one-cycle request strobe (high in SEND)
//   access_code      out  4  code shown to the door controller, 0 when idle
//   granted          out  high while in GRANTED
//   rejected         out  one-cycle pulse on each rejection
//   locked           out  high while in LOCKED
//   state_out        out  3  current state encoding
// ---------------------------------------------------------------------------
module access_code_tx
  import access_pkg::*;
#(
  parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT,
  parameter int MAX_FAILS    = DEF_MAX_FAILS,
  parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_val,
  input  logic       open_access_door,
  output logic       validate_code,
  output logic [3:0] access_code,
  output logic       granted,
  output logic       rejected,
  output logic       locked,
  output logic [2:0] state_out
);

  // One timer serves both intervals, so it is sized for the longer one.
  localparam int TIMER_MAX = (LOCK_CYCLES > RESP_TIMEOUT) ? LOCK_CYCLES : RESP_TIMEOUT;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  // Zero-length intervals or a zero fail limit have no sensible meaning.
  if ((RESP_TIMEOUT < 1) || (MAX_FAILS < 1) || (LOCK_CYCLES < 1)) begin : g_param_check
    $error("access_code_tx: RESP_TIMEOUT, MAX_FAILS and LOCK_CYCLES must be at least 1");
  end

  state_t               r_state;
  state_t               w_state_next;
  logic   [3:0]         r_code;
  logic   [3:0]         w_code_next;
  logic                 w_timer_load;
  logic   [TIMER_W-1:0] w_timer_val;
  logic                 w_timer_en;
  logic                 w_timer_zero;
  logic                 w_reject;
  logic                 w_key_digit;
  logic                 w_key_clear;
  logic                 w_key_enter;

`ifdef ACCESS_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  logic [FAIL_W-1:0] r_fail;
  logic [FAIL_W-1:0] w_fail_next;
  logic [FAIL_W-1:0] w_fail_sat;

  // Saturating increment; in practice the lockout clears the count before
  // it could ever stick at the limit.
  assign w_fail_sat = (r_fail == FAIL_W'(MAX_FAILS)) ? r_fail : r_fail + 1'b1;
`endif

  assign w_key_digit = key_valid && is_digit(key_val);
  assign w_key_clear = key_valid && (key_val == KEY_CLEAR);
  assign w_key_enter = key_valid && (key_val == KEY_ENTER);

`ifdef ACCESS_LOCKOUT_EN
  assign w_timer_en = (r_state == ST_WAIT_RESP) || (r_state == ST_LOCKED);
`else
  assign w_timer_en = (r_state == ST_WAIT_RESP);
`endif

  access_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_timer_load),
    .i_en      (w_timer_en),
    .i_load_val(w_timer_val),
    .o_zero    (w_timer_zero)
  );

  // State, code and fail-count registers. Reset wins over every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
`ifdef ACCESS_LOCKOUT_EN
      r_fail  <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
`ifdef ACCESS_LOCKOUT_EN
      r_fail  <= w_fail_next;
`endif
    end
  end

  // Next-state logic. Keys are only looked at in IDLE and ENTRY; every other
  // state drops them. The timer is loaded with (duration - 1) on the edge
  // that enters WAIT_RESP or LOCKED, so o_zero flags the last cycle there.
  // An open door is tested before the timeout so a coinciding grant wins.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_timer_load = 1'b0;
    w_timer_val  = '0;
    w_reject     = 1'b0;
`ifdef ACCESS_LOCKOUT_EN
    w_fail_next  = r_fail;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_key_digit) begin
          w_code_next  = key_val;
          w_state_next = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (w_key_digit) begin
          w_code_next = key_val;
        end else if (w_key_clear) begin
          w_code_next  = '0;
          w_state_next = ST_IDLE;
        end else if (w_key_enter) begin
          w_state_next = ST_SEND;
        end
      end

      ST_SEND: begin
        w_state_next = ST_WAIT_RESP;
        w_timer_load = 1'b1;
        w_timer_val  = TIMER_W'(RESP_TIMEOUT - 1);
      end

      ST_WAIT_RESP: begin
        if (open_access_door) begin
          w_state_next = ST_GRANTED;
`ifdef ACCESS_LOCKOUT_EN
          w_fail_next  = '0;
`endif
        end else if (w_timer_zero) begin
          w_reject = 1'b1;
`ifdef ACCESS_LOCKOUT_EN
          w_fail_next = w_fail_sat;
          if (w_fail_sat == FAIL_W'(MAX_FAILS)) begin
            w_state_next = ST_LOCKED;
            w_timer_load = 1'b1;
            w_timer_val  = TIMER_W'(LOCK_CYCLES - 1);
          end else begin
            w_state_next = ST_IDLE;
          end
`else
          w_state_next = ST_IDLE;
`endif
        end
      end

      ST_GRANTED: begin
        if (!open_access_door) begin
          w_code_next  = '0;
          w_state_next = ST_IDLE;
        end
      end

`ifdef ACCESS_LOCKOUT_EN
      ST_LOCKED: begin
        if (w_timer_zero) begin
          w_fail_next  = '0;
          w_state_next = ST_IDLE;
        end
      end
`endif

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // The code is only presented while a request is outstanding or granted.
  always_comb begin
    access_code = '0;
    if ((r_state == ST_SEND) || (r_state == ST_WAIT_RESP) || (r_state == ST_GRANTED)) begin
      access_code = r_code;
    end
  end

  assign validate_code = (r_state == ST_SEND);
  assign granted       = (r_state == ST_GRANTED);
  assign state_out     = r_state;

  // The rejection is decided combinationally in the timeout cycle; a reset
  // in that same cycle cancels it, so the pulse is suppressed too.
  assign rejected      = w_reject && !rst;

`ifdef ACCESS_LOCKOUT_EN
  assign locked = (r_state == ST_LOCKED);
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_access_code_tx.sv
// ---------------------------------------------------------------------------
// tb_access_code_tx
// Self-checking bench for access_code_tx. Directed scenarios check the
// headline behaviours against hand-derived numbers; a randomized run checks
// every output each cycle against a behavioural reference model written from
// the block's rules (wait/lock intervals counted upward from zero).
// Define ACCESS_LOCKOUT_EN for both bench and RTL to exercise the lockout.
// ---------------------------------------------------------------------------
module tb_access_code_tx;

  localparam int RT = 4;
  localparam int MF = 3;
  localparam int LC = 64;

  localparam int S_IDLE    = 0;
  localparam int S_ENTRY   = 1;
  localparam int S_SEND    = 2;
  localparam int S_WAIT    = 3;
  localparam int S_GRANTED = 4;
  localparam int S_LOCKED  = 5;

`ifdef ACCESS_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_val;
  logic       open_access_door;
  logic       validate_code;
  logic [3:0] access_code;
  logic       granted;
  logic       rejected;
  logic       locked;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         mState = 0;
  logic [3:0] mCode  = '0;
  int         mWait  = 0;
  int         mFails = 0;
  int         mLock  = 0;

  // Expected outputs for the current cycle.
  logic       eValidate;
  logic [3:0] eCode;
  logic       eGranted;
  logic       eRejected;
  logic       eLocked;
  logic [2:0] eState;

  always #5 clk = ~clk;

  access_code_tx #(
    .RESP_TIMEOUT(RT),
    .MAX_FAILS   (MF),
    .LOCK_CYCLES (LC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .key_valid       (key_valid),
    .key_val         (key_val),
    .open_access_door(open_access_door),
    .validate_code   (validate_code),
    .access_code     (access_code),
    .granted         (granted),
    .rejected        (rejected),
    .locked          (locked),
    .state_out       (state_out)
  );

  // Reference model: advance one clock edge using the inputs held this cycle.
  function automatic void modelNext();
    if (rst) begin
      mState = S_IDLE;
      mCode  = '0;
      mWait  = 0;
      mFails = 0;
      mLock  = 0;
      return;
    end
    case (mState)
      S_IDLE: begin
        if (key_valid && (key_val <= 4'd11)) begin
          mCode  = key_val;
          mState = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (key_valid) begin
          if (key_val <= 4'd11) begin
            mCode = key_val;
          end else if (key_val == 4'd12) begin
            mCode  = '0;
            mState = S_IDLE;
          end else if (key_val == 4'd14) begin
            mState = S_SEND;
          end
        end
      end
      S_SEND: begin
        mState = S_WAIT;
        mWait  = 0;
      end
      S_WAIT: begin
        if (open_access_door) begin
          mState = S_GRANTED;
          mFails = 0;
        end else if (mWait == RT - 1) begin
          if (mFails < MF) mFails++;
          if (LOCKOUT && (mFails == MF)) begin
            mState = S_LOCKED;
            mLock  = 0;
          end else begin
            mState = S_IDLE;
          end
        end else begin
          mWait++;
        end
      end
      S_GRANTED: begin
        if (!open_access_door) begin
          mState = S_IDLE;
          mCode  = '0;
        end
      end
      S_LOCKED: begin
        if (mLock == LC - 1) begin
          mState = S_IDLE;
          mFails = 0;
        end else begin
          mLock++;
        end
      end
      default: mState = S_IDLE;
    endcase
  endfunction

  // Reference model: outputs for the current state and inputs.
  function automatic void modelExpect();
    eValidate = (mState == S_SEND);
    eCode     = ((mState == S_SEND) || (mState == S_WAIT) || (mState == S_GRANTED)) ? mCode : 4'd0;
    eGranted  = (mState == S_GRANTED);
    eRejected = (mState == S_WAIT) && !open_access_door && (mWait == RT - 1) && !rst;
    eLocked   = (mState == S_LOCKED);
    eState    = 3'(mState);
  endfunction

  // Drive one cycle's inputs just after an edge and let outputs settle.
  task automatic applyStimulus(input logic kv, input logic [3:0] kval,
                               input logic door, input logic r);
    rst              = r;
    key_valid        = kv;
    key_val          = kval;
    open_access_door = door;
    #2;
    modelExpect();
  endtask

  task automatic finishCycle();
    @(posedge clk);
    modelNext();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
      finishCycle();
      checks++; if (state_out !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state_out); end
      checks++; if (validate_code !== 1'b0) begin errors++; $display("[TB] FAIL reset_validate: got %b expected 0", validate_code); end
      checks++; if (access_code !== 4'd0) begin errors++; $display("[TB] FAIL reset_code: got %0h expected 0", access_code); end
      checks++; if (granted !== 1'b0) begin errors++; $display("[TB] FAIL reset_granted: got %b expected 0", granted); end
      checks++; if (rejected !== 1'b0) begin errors++; $display("[TB] FAIL reset_rejected: got %b expected 0", rejected); end
      checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
    end
  endtask

  task automatic test_grant();
    int   v      = -1;
    int   nVal   = 0;
    int   nGrant = 0;
    int   codeBad = 0;
    logic door;
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b0); finishCycle();
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0); finishCycle();
    for (int c = 0; c < 30; c++) begin
      door = (v >= 0) && (c >= v + 2) && (c < v + 18);
      applyStimulus(1'b0, 4'd0, door, 1'b0);
      if (validate_code === 1'b1) begin
        nVal++;
        if (v < 0) v = c;
      end
      if (granted === 1'b1) nGrant++;
      if ((state_out inside {3'd2, 3'd3, 3'd4}) && (access_code !== 4'd9)) codeBad++;
      finishCycle();
    end
    checks++; if (v !== 0) begin errors++; $display("[TB] FAIL grant_validate_latency: got cycle %0d expected 0", v); end
    checks++; if (nVal !== 1) begin errors++; $display("[TB] FAIL grant_validate_count: got %0d expected 1", nVal); end
    checks++; if (nGrant !== 16) begin errors++; $display("[TB] FAIL grant_cycles: got %0d expected 16", nGrant); end
    checks++; if (codeBad !== 0) begin errors++; $display("[TB] FAIL grant_code_stable: got %0d bad cycles expected 0", codeBad); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("[TB] FAIL grant_end_state: got %0d expected 0", state_out); end
    checks++; if (access_code !== 4'd0) begin errors++; $display("[TB] FAIL grant_end_code: got %0h expected 0", access_code); end
  endtask

  task automatic test_reject();
    int nRej = 0;
    int rc   = -1;
    int codeBad = 0;
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0); finishCycle();
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0); finishCycle();
    for (int c = 0; c <= RT; c++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
      if (rejected === 1'b1) begin nRej++; rc = c; end
      if (access_code !== 4'd2) codeBad++;
      finishCycle();
    end
    checks++; if (nRej !== 1) begin errors++; $display("[TB] FAIL reject_count: got %0d expected 1", nRej); end
    checks++; if (rc !== RT) begin errors++; $display("[TB] FAIL reject_cycle: got %0d expected %0d", rc, RT); end
    checks++; if (codeBad !== 0) begin errors++; $display("[TB] FAIL reject_code: got %0d bad cycles expected 0", codeBad); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("[TB] FAIL reject_end_state: got %0d expected 0", state_out); end
  endtask

  task automatic test_clear();
    logic [3:0] keys  [4];
    int         expSt [4];
    int         nVal = 0;
    keys  = '{4'd3, 4'd7, 4'hC, 4'hE};
    expSt = '{1, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, keys[i], 1'b0, 1'b0);
      finishCycle();
      checks++; if (state_out !== 3'(expSt[i])) begin errors++; $display("[TB] FAIL clear_state_%0d: got %0d expected %0d", i, state_out, expSt[i]); end
    end
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
      if (validate_code === 1'b1) nVal++;
      finishCycle();
    end
    checks++; if (nVal !== 0) begin errors++; $display("[TB] FAIL clear_validate: got %0d pulses expected 0", nVal); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("[TB] FAIL clear_end_state: got %0d expected 0", state_out); end
  endtask

  task automatic test_reset_in_wait();
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0); finishCycle();
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0); finishCycle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0); finishCycle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0); finishCycle();
    applyStimulus(1'b1, 4'd6, 1'b1, 1'b1);
    checks++; if (state_out !== 3'd3) begin errors++; $display("[TB] FAIL rstwait_pre_state: got %0d expected 3", state_out); end
    finishCycle();
    checks++; if (state_out !== 3'd0) begin errors++; $display("[TB] FAIL rstwait_state: got %0d expected 0", state_out); end
    checks++; if (validate_code !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_validate: got %b expected 0", validate_code); end
    checks++; if (access_code !== 4'd0) begin errors++; $display("[TB] FAIL rstwait_code: got %0h expected 0", access_code); end
    checks++; if (granted !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_granted: got %b expected 0", granted); end
    checks++; if (rejected !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_rejected: got %b expected 0", rejected); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_locked: got %b expected 0", locked); end
  endtask

  task automatic test_timeout_grant();
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b0); finishCycle();
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0); finishCycle();
    for (int c = 0; c < RT; c++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0); finishCycle();
    end
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    checks++; if (state_out !== 3'd3) begin errors++; $display("[TB] FAIL tograt_pre_state: got %0d expected 3", state_out); end
    checks++; if (rejected !== 1'b0) begin errors++; $display("[TB] FAIL tograt_rejected: got %b expected 0", rejected); end
    finishCycle();
    checks++; if (granted !== 1'b1) begin errors++; $display("[TB] FAIL tograt_granted: got %b expected 1", granted); end
    checks++; if (access_code !== 4'd4) begin errors++; $display("[TB] FAIL tograt_code: got %0h expected 4", access_code); end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0); finishCycle();
    checks++; if (state_out !== 3'd0) begin errors++; $display("[TB] FAIL tograt_end_state: got %0d expected 0", state_out); end
  endtask

  task automatic attemptReject(input logic [3:0] d, output int nRej, output int stAfter);
    nRej = 0;
    applyStimulus(1'b1, d, 1'b0, 1'b0); finishCycle();
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0); finishCycle();
    for (int c = 0; c <= RT; c++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
      if (rejected === 1'b1) nRej++;
      finishCycle();
    end
    stAfter = int'(state_out);
  endtask

  task automatic test_lockout();
    int nRej;
    int st;
`ifdef ACCESS_LOCKOUT_EN
    int nLocked = 0;
    int badSt   = 0;
    bit done    = 1'b0;
    for (int k = 0; k < MF; k++) begin
      attemptReject(4'(k + 1), nRej, st);
      checks++; if (nRej !== 1) begin errors++; $display("[TB] FAIL lock_reject_%0d: got %0d expected 1", k, nRej); end
      checks++; if (st !== ((k == MF - 1) ? 5 : 0)) begin errors++; $display("[TB] FAIL lock_state_%0d: got %0d expected %0d", k, st, (k == MF - 1) ? 5 : 0); end
    end
    for (int c = 0; (c < LC + 10) && !done; c++) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      if (locked === 1'b1) begin
        nLocked++;
        if (state_out !== 3'd5) badSt++;
      end else begin
        done = 1'b1;
      end
      if (!done) finishCycle();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL lock_release: got still locked expected release within %0d cycles", LC + 10); end
    checks++; if (nLocked !== LC) begin errors++; $display("[TB] FAIL lock_cycles: got %0d expected %0d", nLocked, LC); end
    checks++; if (badSt !== 0) begin errors++; $display("[TB] FAIL lock_keys_ignored: got %0d bad cycles expected 0", badSt); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("[TB] FAIL lock_end_state: got %0d expected 0", state_out); end
    for (int k = 0; k < MF; k++) begin
      attemptReject(4'd8, nRej, st);
      checks++; if (st !== ((k == MF - 1) ? 5 : 0)) begin errors++; $display("[TB] FAIL lock_fails_cleared_%0d: got %0d expected %0d", k, st, (k == MF - 1) ? 5 : 0); end
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1); finishCycle();
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_reset: got %b expected 0", locked); end
`else
    for (int k = 0; k < MF + 1; k++) begin
      attemptReject(4'(k + 1), nRej, st);
      checks++; if (nRej !== 1) begin errors++; $display("[TB] FAIL nolock_reject_%0d: got %0d expected 1", k, nRej); end
      checks++; if (st !== 0) begin errors++; $display("[TB] FAIL nolock_state_%0d: got %0d expected 0", k, st); end
      checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL nolock_locked_%0d: got %b expected 0", k, locked); end
    end
`endif
  endtask

  task automatic test_random();
    logic       kv;
    logic [3:0] kval;
    logic       door;
    logic       r;
    int         sel;
    for (int i = 0; i < 3000; i++) begin
      kv  = ($urandom_range(0, 99) < 40);
      sel = $urandom_range(0, 9);
      if (sel < 6)       kval = 4'($urandom_range(0, 11));
      else if (sel < 8)  kval = 4'hC;
      else if (sel == 8) kval = 4'hE;
      else               kval = 4'($urandom_range(0, 15));
      door = (mState == S_GRANTED) ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 20);
      r    = ($urandom_range(0, 299) == 0);
      applyStimulus(kv, kval, door, r);
      checks++; if (validate_code !== eValidate) begin errors++; $display("[TB] FAIL rand_validate @%0d: got %b expected %b", i, validate_code, eValidate); end
      checks++; if (access_code !== eCode) begin errors++; $display("[TB] FAIL rand_code @%0d: got %0h expected %0h", i, access_code, eCode); end
      checks++; if (granted !== eGranted) begin errors++; $display("[TB] FAIL rand_granted @%0d: got %b expected %b", i, granted, eGranted); end
      checks++; if (rejected !== eRejected) begin errors++; $display("[TB] FAIL rand_rejected @%0d: got %b expected %b", i, rejected, eRejected); end
      checks++; if (locked !== eLocked) begin errors++; $display("[TB] FAIL rand_locked @%0d: got %b expected %b", i, locked, eLocked); end
      checks++; if (state_out !== eState) begin errors++; $display("[TB] FAIL rand_state @%0d: got %0d expected %0d", i, state_out, eState); end
      finishCycle();
    end
  endtask

  initial begin
    rst              = 1'b1;
    key_valid        = 1'b0;
    key_val          = 4'd0;
    open_access_door = 1'b0;
    $display("[TB] access_code_tx bench start (lockout=%0d)", LOCKOUT);
    test_reset();
    test_grant();
    test_reject();
    test_clear();
    test_reset_in_wait();
    test_timeout_grant();
    test_lockout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/access_code_tx.md
ACCESS_CODE_TX -- requirements
Module: access_code_tx

Interface
- REQ-001: Parameter RESP_TIMEOUT, default 4; cycles in WAIT_RESP without the door opening before a rejection.
- REQ-002: Parameter MAX_FAILS, default 3; consecutive rejections that trigger lockout.
- REQ-003: Parameter LOCK_CYCLES, default 64; lockout duration in cycles.
- REQ-004: clk  in  1  single clock; all logic on the rising edge.
- REQ-005: rst  in  1  reset, synchronous, active-high.
- REQ-006: key_valid  in  1  one-cycle strobe marking a keypad press.
- REQ-007: key_val  in  4  key code: 0x0-0xB digit, 0xC clear, 0xE enter, others ignored.
- REQ-008: open_access_door  in  1  door-open indication from the door controller.
- REQ-009: validate_code  out  1  request strobe to the door controller.
- REQ-010: access_code  out  4  code presented to the door controller.
- REQ-011: granted  out  1  high while in GRANTED.
- REQ-012: rejected  out  1  one-cycle pulse on each rejection.
- REQ-013: locked  out  1  high while in LOCKED.
- REQ-014: state_out  out  3  current state encoding.

Function
- REQ-015: States SHALL be IDLE=0, ENTRY=1, SEND=2, WAIT_RESP=3, GRANTED=4, LOCKED=5; undefined encodings SHALL go to IDLE on the next edge.
- REQ-016: In IDLE or ENTRY, a digit key SHALL load code_reg with key_val and move to ENTRY; the last digit wins.
- REQ-017: In ENTRY, a clear key (0xC) SHALL zero code_reg and return to IDLE; in IDLE, clear SHALL have no effect.
- REQ-018: In ENTRY, an enter key (0xE) SHALL move to SEND; in IDLE, enter SHALL be ignored.
- REQ-019: In SEND, validate_code SHALL be 1 for exactly one cycle, and the state SHALL then move to WAIT_RESP.
- REQ-020: access_code SHALL equal code_reg and SHALL stay stable from SEND through the end of WAIT_RESP/GRANTED; otherwise it SHALL be 0.
- REQ-021: WAIT_RESP SHALL count cycles from 0; open_access_door=1 SHALL move to GRANTED and clear the fail counter.
- REQ-022: If the count reaches RESP_TIMEOUT-1 with open_access_door=0, the block SHALL pulse rejected, increment the fail counter (saturating) and go to IDLE (or LOCKED per REQ-029).
- REQ-023: If open_access_door=1 coincides with the timeout cycle, the grant SHALL take priority.
- REQ-024: GRANTED SHALL be held until open_access_door=0, then go to IDLE with code_reg zeroed.
- REQ-025: Keys SHALL be ignored in SEND, WAIT_RESP, GRANTED and LOCKED; no key buffering.
- REQ-026: Latency: enter press to validate_code=1 SHALL be exactly 1 cycle after the enter-sampling edge.

Reset
- REQ-027: rst=1 at an edge SHALL force IDLE, code_reg=0, all counters=0, and every output=0; it SHALL abort any state, including mid-WAIT_RESP and mid-LOCKED.
- REQ-028: Reset SHALL take precedence over every simultaneous input.

Configuration
- REQ-029: With ACCESS_LOCKOUT_EN defined, a rejection that brings the fail counter to MAX_FAILS SHALL go to LOCKED.
- REQ-030: LOCKED SHALL hold for LOCK_CYCLES cycles, then go to IDLE with the fail counter cleared.
- REQ-031: Without ACCESS_LOCKOUT_EN, the LOCKED state, lock counter and fail counter SHALL be absent, and locked SHALL be tied to 0.

Structure
- REQ-032: A shared package access_pkg SHALL hold the state encoding constants and key codes (KEY_CLEAR=0xC, KEY_ENTER=0xE).
- REQ-033: The shared package SHALL also hold the parameter defaults.
- REQ-034: One sub-module, access_timer, SHALL be used: a loadable down-counter shared by the WAIT_RESP timeout and the lockout; no other hierarchy.

Verification
- REQ-035: Digit 9, then enter, with the door model asserting open 2 cycles after validate for 16 cycles -> validate_code pulses once; access_code=9 throughout; granted=1 until open falls; then IDLE.
- REQ-036: Digit 2, then enter, no door response -> rejected pulses on cycle 4 of WAIT_RESP; access_code=2 until then; state_out=0 afterwards.
- REQ-037: Three consecutive rejections with ACCESS_LOCKOUT_EN defined -> locked=1 for 64 cycles; keys pressed during lockout are ignored; fail counter is 0 afterwards.
- REQ-038: Digits 3 then 7, clear, then enter -> no validate_code; state stays IDLE.
- REQ-039: rst asserted in the 2nd cycle of WAIT_RESP -> all outputs are 0 and state_out=0 on the next edge.
- REQ-040: open_access_door rising on the timeout cycle -> granted=1 and no rejected pulse.
